// File: rtl/status_led_pkg.sv
// Shared types, colour constants and priority encoder for the status LED scheduler.
package status_led_pkg;

   typedef logic [23:0] rgb_t;

   localparam rgb_t BLACK  = 24'h00_00_00;
   localparam rgb_t RED    = 24'h10_00_00;
   localparam rgb_t BR_RED = 24'h80_00_00;
   localparam rgb_t GREEN  = 24'h00_08_00;
   localparam rgb_t BLUE   = 24'h00_00_04;

   typedef enum logic [1:0] {IDLE, HOLD, OPEN} chan_state_t;

   // Lowest asserted index wins; returns 0 when nothing is asserted.
   function automatic logic [2:0] prio_idx(input logic [7:0] req);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/status_led_chan.sv
// One LED channel: priority grant, minimum-display hold timer and registered colour output.
module status_led_chan
   import status_led_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned HOLD_CYCLES = 2_000_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_i,
   input  logic [24*N_REQ-1:0]  color_i,
   input  logic [N_REQ-1:0]     blink_i,
   input  logic                 phase_i,
   output logic [7:0]           r_o,
   output logic [7:0]           g_o,
   output logic [7:0]           b_o,
   output logic [2:0]           owner_o,
   output logic                 busy_o
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   chan_state_t   state_q, state_d;
   logic [2:0]    owner_q, owner_d;
   logic [HW-1:0] hold_q, hold_d;
   rgb_t          col_q, col_d;
   logic          blk_q, blk_d;
   rgb_t          out_q, out_d;

   logic [7:0] req_pad, blk_pad;
   rgb_t       col_arr [8];
   logic [2:0] win;
   logic       any_req, own_req;
   logic       open_eval, grant, track, release_ch;

   always_comb begin
      req_pad = 8'(req_i);
      blk_pad = 8'(blink_i);
      for (int i = 0; i < 8; i++) col_arr[i] = BLACK;
      for (int i = 0; i < int'(N_REQ); i++) col_arr[i] = color_i[24*i +: 24];
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      hold_d     = hold_q;
      col_d      = col_q;
      blk_d      = blk_q;
      win        = prio_idx(req_pad);
      any_req    = |req_pad;
      own_req    = req_pad[owner_q];
      open_eval  = 1'b0;
      grant      = 1'b0;
      track      = 1'b0;
      release_ch = 1'b0;

      unique case (state_q)
         IDLE: grant = any_req;
         HOLD: begin
            if (hold_q != '0) begin
               hold_d = hold_q - 1'b1;
               track  = own_req;
            end else begin
               // Expiry edge already counts as the first open decision.
               open_eval = 1'b1;
            end
         end
         OPEN:    open_eval = 1'b1;
         default: release_ch = 1'b1;
      endcase

      if (open_eval) begin
         if (!own_req) begin
            if (any_req) grant = 1'b1;
            else         release_ch = 1'b1;
         end else if (win < owner_q) begin
            grant = 1'b1;
         end else begin
            state_d = OPEN;
            track   = 1'b1;
         end
      end

      if (track) begin
         col_d = col_arr[owner_q];
         blk_d = blk_pad[owner_q];
      end
      if (grant) begin
         state_d = HOLD;
         owner_d = win;
         hold_d  = HOLD_LOAD;
         col_d   = col_arr[win];
         blk_d   = blk_pad[win];
      end
      if (release_ch) begin
         state_d = IDLE;
         owner_d = 3'd0;
         col_d   = BLACK;
         blk_d   = 1'b0;
      end

      out_d = ((state_d == IDLE) || (blk_d && !phase_i)) ? BLACK : col_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 3'd0;
         hold_q  <= '0;
         col_q   <= BLACK;
         blk_q   <= 1'b0;
         out_q   <= BLACK;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         col_q   <= col_d;
         blk_q   <= blk_d;
         out_q   <= out_d;
      end
   end

   assign r_o     = out_q[23:16];
   assign g_o     = out_q[15:8];
   assign b_o     = out_q[7:0];
   assign owner_o = owner_q;
   assign busy_o  = (state_q != IDLE);

endmodule

// File: rtl/status_led_sched.sv
// Status LED scheduler top: shared blink generator feeding two independent LED channels.
module status_led_sched
   import status_led_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned HOLD_CYCLES = 2_000_000,
   parameter int unsigned BLINK_HALF  = 12_500_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     led16_req,
   input  logic [24*N_REQ-1:0]  led16_color,
   input  logic [N_REQ-1:0]     led16_blink,
   input  logic [N_REQ-1:0]     led17_req,
   input  logic [24*N_REQ-1:0]  led17_color,
   input  logic [N_REQ-1:0]     led17_blink,
   output logic [7:0]           led16_r,
   output logic [7:0]           led16_g,
   output logic [7:0]           led16_b,
   output logic [7:0]           led17_r,
   output logic [7:0]           led17_g,
   output logic [7:0]           led17_b,
   output logic [2:0]           led16_owner,
   output logic [2:0]           led17_owner,
   output logic                 led16_busy,
   output logic                 led17_busy
);

   localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

   // Channels register their output with the upcoming phase so colour and blink stay aligned.
   status_led_chan #(
      .N_REQ       (N_REQ),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_led16 (
      .clk     (clk),
      .reset   (reset),
      .req_i   (led16_req),
      .color_i (led16_color),
      .blink_i (led16_blink),
      .phase_i (phase_d),
      .r_o     (led16_r),
      .g_o     (led16_g),
      .b_o     (led16_b),
      .owner_o (led16_owner),
      .busy_o  (led16_busy)
   );

   status_led_chan #(
      .N_REQ       (N_REQ),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_led17 (
      .clk     (clk),
      .reset   (reset),
      .req_i   (led17_req),
      .color_i (led17_color),
      .blink_i (led17_blink),
      .phase_i (phase_d),
      .r_o     (led17_r),
      .g_o     (led17_g),
      .b_o     (led17_b),
      .owner_o (led17_owner),
      .busy_o  (led17_busy)
   );

endmodule

// File: tb/tb_status_led_sched.sv
// Self-checking bench for status_led_sched: vector table, directed corner cases, random vs model.
module tb_status_led_sched;

   localparam int N  = 4;
   localparam int HC = 8;
   localparam int BH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req16, blk16, req17, blk17;
   logic [95:0] col16, col17;
   logic [7:0]  r16, g16, b16, r17, g17, b17;
   logic [2:0]  own16, own17;
   logic        busy16, busy17;

   always #5 clk = ~clk;

   status_led_sched #(
      .N_REQ       (N),
      .HOLD_CYCLES (HC),
      .BLINK_HALF  (BH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .led16_req   (req16),
      .led16_color (col16),
      .led16_blink (blk16),
      .led17_req   (req17),
      .led17_color (col17),
      .led17_blink (blk17),
      .led16_r     (r16),
      .led16_g     (g16),
      .led16_b     (b16),
      .led17_r     (r17),
      .led17_g     (g17),
      .led17_b     (b17),
      .led16_owner (own16),
      .led17_owner (own17),
      .led16_busy  (busy16),
      .led17_busy  (busy17)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: a grant is remembered with the edge number it happened on; the
   // owner is locked until HC edges have elapsed since then.
   typedef struct {
      bit          busy;
      int          owner;
      int          gedge;
      logic [23:0] col;
      bit          blk;
   } ch_m_t;

   ch_m_t m16, m17;
   int    nr = 0;

   function automatic ch_m_t mstep(input ch_m_t m, input logic [3:0] req, input logic [95:0] col,
                                   input logic [3:0] blk, input int e);
      ch_m_t n;
      int    win;
      bit    do_grant;
      n        = m;
      win      = -1;
      do_grant = 1'b0;
      for (int i = 3; i >= 0; i--) if (req[i]) win = i;
      if (!m.busy) begin
         do_grant = (win >= 0);
      end else if (e - m.gedge < HC) begin
         if (req[m.owner]) begin
            n.col = col[24*m.owner +: 24];
            n.blk = blk[m.owner];
         end
      end else if (!req[m.owner]) begin
         if (win >= 0) do_grant = 1'b1;
         else begin
            n.busy  = 1'b0;
            n.owner = 0;
         end
      end else if (win < m.owner) begin
         do_grant = 1'b1;
      end else begin
         n.col = col[24*m.owner +: 24];
         n.blk = blk[m.owner];
      end
      if (do_grant) begin
         n.busy  = 1'b1;
         n.owner = win;
         n.gedge = e;
         n.col   = col[24*win +: 24];
         n.blk   = blk[win];
      end
      return n;
   endfunction

   function automatic logic [23:0] mrgb(input ch_m_t m, input int edges);
      bit lit;
      lit = ((edges / BH) % 2) == 0;
      if (!m.busy || (m.blk && !lit)) return 24'h0;
      return m.col;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         m16 = '{default: 0};
         m17 = '{default: 0};
         nr  = 0;
      end else begin
         nr++;
         m16 = mstep(m16, req16, col16, blk16, nr);
         m17 = mstep(m17, req17, col17, blk17, nr);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_model();
      chk("m16_rgb", {r16, g16, b16}, mrgb(m16, nr));
      chk("m16_own", own16, m16.busy ? m16.owner : 0);
      chk("m16_busy", busy16, m16.busy);
      chk("m17_rgb", {r17, g17, b17}, mrgb(m17, nr));
      chk("m17_own", own17, m17.busy ? m17.owner : 0);
      chk("m17_busy", busy17, m17.busy);
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [2:0]  own;
      logic        busy;
      logic [23:0] rgb;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic [3:0] req, input logic [2:0] own, input logic busy,
                               input logic [23:0] rgb);
      vq.push_back('{req: req, own: own, busy: busy, rgb: rgb});
   endfunction

   localparam logic [95:0] COLS = {24'h000004, 24'h000800, 24'h100000, 24'h800000};

   initial begin
      int lit_cnt;
      reset = 1'b1;
      req16 = '0; blk16 = '0; col16 = COLS;
      req17 = '0; blk17 = '0; col17 = COLS;
      tick();
      tick();
      chk("rst_rgb16", {r16, g16, b16}, 24'h0);
      chk("rst_rgb17", {r17, g17, b17}, 24'h0);
      chk("rst_own", {own16, own17}, 6'h0);
      chk("rst_busy", {busy16, busy17}, 2'b00);
      reset = 1'b0;

      // Single-cycle pulse, minimum display, simultaneous requests and hand-over in OPEN.
      add(4'b0100, 3'd2, 1'b1, 24'h000800);
      for (int i = 0; i < 7; i++) add(4'b0000, 3'd2, 1'b1, 24'h000800);
      add(4'b0000, 3'd0, 1'b0, 24'h000000);
      for (int i = 0; i < 9; i++) add(4'b1010, 3'd1, 1'b1, 24'h100000);
      add(4'b1000, 3'd3, 1'b1, 24'h000004);
      add(4'b0000, 3'd3, 1'b1, 24'h000004);
      foreach (vq[k]) begin
         req16 = vq[k].req;
         tick();
         chk($sformatf("vec%0d_rgb", k), {r16, g16, b16}, vq[k].rgb);
         chk($sformatf("vec%0d_own", k), own16, vq[k].own);
         chk($sformatf("vec%0d_busy", k), busy16, vq[k].busy);
      end

      // Pre-emption attempt during HOLD is ignored until the hold expires.
      req16 = '0;
      do_reset();
      req16 = 4'b1000;
      tick();
      chk("hpre_grant", own16, 3'd3);
      tick();
      tick();
      req16 = 4'b1001;
      for (int k = 3; k < HC; k++) begin
         tick();
         chk("hpre_locked", own16, 3'd3);
      end
      tick();
      chk("hpre_own", own16, 3'd0);
      chk("hpre_rgb", {r16, g16, b16}, 24'h800000);

      // Pre-emption in OPEN, then a full hold of the new owner.
      req16 = '0;
      do_reset();
      req16 = 4'b0010;
      repeat (HC + 1) tick();
      chk("opre_open", own16, 3'd1);
      req16 = 4'b0011;
      tick();
      chk("opre_own", own16, 3'd0);
      chk("opre_rgb", {r16, g16, b16}, 24'h800000);
      req16 = 4'b0010;
      for (int k = 1; k < HC; k++) begin
         tick();
         chk("opre_hold", {5'h0, own16, r16, g16, b16}, {8'h00, 24'h800000});
      end
      tick();
      chk("opre_back", own16, 3'd1);
      chk("opre_back_rgb", {r16, g16, b16}, 24'h100000);

      // Blink: half-lit over two full periods, then steady when blink drops.
      req16 = '0;
      do_reset();
      col16[23:0] = 24'h000004;
      blk16 = 4'b0001;
      req16 = 4'b0001;
      lit_cnt = 0;
      repeat (4 * BH) begin
         tick();
         chk_model();
         if ({r16, g16, b16} == 24'h000004) lit_cnt++;
      end
      chk("blink_duty", lit_cnt, 2 * BH);
      blk16 = '0;
      tick();
      repeat (2 * BH) begin
         tick();
         chk("blink_off", {r16, g16, b16}, 24'h000004);
      end

      // Channel independence and reset mid-HOLD on both LEDs.
      req16 = '0;
      col16 = COLS;
      do_reset();
      req16 = 4'b0100;
      tick();
      tick();
      req17 = 4'b1000;
      tick();
      chk("indep_own17", own17, 3'd3);
      chk("indep_rgb17", {r17, g17, b17}, 24'h000004);
      chk("indep_own16", own16, 3'd2);
      reset = 1'b1;
      tick();
      chk("mrst_rgb", {r16, g16, b16, r17, g17, b17}, 48'h0);
      chk("mrst_own", {own16, own17}, 6'h0);
      chk("mrst_busy", {busy16, busy17}, 2'b00);
      reset = 1'b0;
      req16 = '0;
      req17 = '0;

      // Randomised traffic against the model.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) req16[i] = ~req16[i];
            if ($urandom_range(0, 7) == 0) req17[i] = ~req17[i];
            if ($urandom_range(0, 15) == 0) col16[24*i +: 24] = 24'($urandom);
            if ($urandom_range(0, 15) == 0) col17[24*i +: 24] = 24'($urandom);
            if ($urandom_range(0, 31) == 0) blk16[i] = ~blk16[i];
            if ($urandom_range(0, 31) == 0) blk17[i] = ~blk17[i];
         end
         reset = ($urandom_range(0, 199) == 0);
         tick();
         chk_model();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
